spike_encoder42: RTL

//  Rate-coded spike transmitter: drives the 42 synapse event lines of a neuron42s-class

---
 rtl/spike_pkg.sv | 11 +
 rtl/popcount42.sv | 10 +
 rtl/spike_encoder42.sv | 74 +++++++
 3 files changed

// File: rtl/spike_pkg.sv
// spike_pkg: shared widths, state encoding and count-width helper for spike_encoder42
package spike_pkg;
  localparam int P_CHANNELS = 42;
  localparam int P_WIDTH = 8;
  localparam int P_WIN_W = 16;
  function automatic int cnt_width(input int win_w);
    return win_w + $clog2(P_CHANNELS + 1);
  endfunction
  localparam int P_CNT_W = cnt_width(P_WIN_W);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/popcount42.sv
// popcount42: combinational population count of a 42-bit vector
module popcount42 (
  input  logic [41:0] vec_i,
  output logic [5:0]  cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 42; i++) cnt_o = cnt_o + 6'(vec_i[i]);
  end
endmodule

// File: rtl/spike_encoder42.sv
// spike_encoder42: rate-coded phase-accumulator spike transmitter for 42 synapse lines
module spike_encoder42
  import spike_pkg::*;
#(
  parameter int p_channels = P_CHANNELS,
  parameter int p_width = P_WIDTH,
  parameter int p_win_w = P_WIN_W,
  parameter int p_cnt_w = P_CNT_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [p_channels*p_width-1:0] i_rate,
  input  logic [p_win_w-1:0]            i_window,
  input  logic                          i_start,
  input  logic                          i_abort,
  output logic [p_channels:1]           o_event,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [p_cnt_w-1:0]            o_spike_cnt
);
  state_e state_q, state_d;
  logic [p_win_w-1:0] win_q, win_d;
  logic [p_channels:1] ev_q, carry;
  logic [p_cnt_w-1:0] cnt_q, cnt_d;
  logic [p_cnt_w:0] cnt_sum;
  logic [5:0] pop;
  logic accept, step;
  assign accept = (state_q == ST_IDLE) && i_start && (i_window != '0) && !i_abort;
  assign step = (state_q == ST_RUN) && !i_abort;
  for (genvar g = 1; g <= p_channels; g++) begin : g_ch
    logic [p_width-1:0] acc_q, rate_q;
    logic [p_width:0] sum;
    assign sum = {1'b0, acc_q} + {1'b0, rate_q};
    assign carry[g] = sum[p_width];
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        acc_q <= '0;
        rate_q <= '0;
      end else if (accept) begin
        acc_q <= '0;
        rate_q <= i_rate[g*p_width-1 -: p_width];
      end else if (step) begin
        acc_q <= sum[p_width-1:0];
      end
    end
  end
  popcount42 u_pop (.vec_i(ev_q), .cnt_o(pop));
  always_comb begin
    state_d = accept ? ST_RUN :
              state_q == ST_RUN ? (i_abort ? ST_IDLE : win_q == p_win_w'(1) ? ST_DONE : ST_RUN) :
              state_q == ST_DONE ? ST_IDLE : state_q;
    win_d = accept ? i_window : step ? win_q - p_win_w'(1) : win_q;
    cnt_sum = {1'b0, cnt_q} + {{(p_cnt_w-5){1'b0}}, pop};
    // events on o_event are tallied the cycle they are visible, saturating at all-ones
    cnt_d = accept ? '0 : cnt_sum[p_cnt_w] ? '1 : cnt_sum[p_cnt_w-1:0];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      win_q <= '0;
      ev_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      ev_q <= step ? carry : '0;
      cnt_q <= cnt_d;
    end
  end
  assign o_event = ev_q;
  assign o_busy = state_q == ST_RUN;
  assign o_done = state_q == ST_DONE;
  assign o_spike_cnt = cnt_q;
endmodule
